// File: rtl/magnetron_sequencer_if.sv
// Keypad, button and door inputs plus status outputs of the magnetron sequencer.
// The sequencer takes the slave modport; whoever drives the buttons takes the master.
interface magnetron_sequencer_if;
    logic        startn;
    logic        stopn;
    logic        clearn;
    logic        door_closed;
    logic        digit_valid;
    logic [3:0]  digit;
    logic        mag_on;
    logic [15:0] time_bcd;
    logic [2:0]  state;
    logic        done;
    logic        beep;

    modport master (
        output startn, stopn, clearn, door_closed, digit_valid, digit,
        input  mag_on, time_bcd, state, done, beep
    );

    modport slave (
        input  startn, stopn, clearn, door_closed, digit_valid, digit,
        output mag_on, time_bcd, state, done, beep
    );
endinterface

// File: rtl/magnetron_sequencer.sv
// Microwave cooking sequencer: keypad MM:SS entry, 1 s BCD countdown, door/pause/+30 s control.
// Optional macro DONE_BEEP_EN: beep for BEEP_SECS seconds on entering DONE.
module magnetron_sequencer #(
    parameter int TICK_DIV  = 50000000,
    parameter int BEEP_SECS = 3
) (
    input logic                  clk,
    input logic                  rst,
    magnetron_sequencer_if.slave bus
);
    localparam int PRE_W = (TICK_DIV > 2) ? $clog2(TICK_DIV) : 1;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        SETUP = 3'd1,
        COOK  = 3'd2,
        PAUSE = 3'd3,
        DONE  = 3'd4
    } state_e;

    state_e             state_q, state_d;
    logic [15:0]        time_q, time_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [2:0]         btn_sync_q, btn_prev_q;
    logic               door_q;
    logic               ev_clear, ev_stop, ev_start;
    logic               door_fall, digit_ok, pre_run, tick;

    function automatic logic [7:0] to_bcd(input logic [7:0] v);
        return {4'(v / 8'd10), 4'(v % 8'd10)};
    endfunction

    // Borrowing BCD decrement; seconds tens above 5 simply count down through 9x.
    function automatic logic [15:0] bcd_dec(input logic [15:0] t);
        logic [3:0] mt, mo, st, so;
        {mt, mo, st, so} = t;
        if (so != 4'd0) begin
            so = so - 4'd1;
        end else if (st != 4'd0) begin
            st = st - 4'd1;
            so = 4'd9;
        end else begin
            st = 4'd5;
            so = 4'd9;
            if (mo != 4'd0) begin
                mo = mo - 4'd1;
            end else begin
                mt = mt - 4'd1;
                mo = 4'd9;
            end
        end
        return {mt, mo, st, so};
    endfunction

    // +30 s with seconds renormalised to 00-59 and saturation at 99:59.
    function automatic logic [15:0] bcd_add30(input logic [15:0] t);
        logic [7:0] secs, mins, carry;
        secs  = 8'(t[7:4]) * 8'd10 + 8'(t[3:0]) + 8'd30;
        carry = 8'd0;
        if (secs >= 8'd120) begin
            secs  = secs - 8'd120;
            carry = 8'd2;
        end else if (secs >= 8'd60) begin
            secs  = secs - 8'd60;
            carry = 8'd1;
        end
        mins = 8'(t[15:12]) * 8'd10 + 8'(t[11:8]) + carry;
        if (mins > 8'd99) begin
            return 16'h9959;
        end
        return {to_bcd(mins), to_bcd(secs)};
    endfunction

    assign ev_clear  = btn_prev_q[2] & ~btn_sync_q[2];
    assign ev_stop   = btn_prev_q[1] & ~btn_sync_q[1];
    assign ev_start  = btn_prev_q[0] & ~btn_sync_q[0];
    assign door_fall = door_q & ~bus.door_closed;
    assign digit_ok  = bus.digit_valid && (bus.digit <= 4'd9);

`ifdef DONE_BEEP_EN
    assign pre_run = (state_q == COOK) || (state_q == DONE);
`else
    assign pre_run = (state_q == COOK);
`endif
    assign tick = pre_run && (pre_q == PRE_W'(TICK_DIV - 1));

    always_comb begin
        state_d = state_q;
        time_d  = time_q;
        case (state_q)
            IDLE, SETUP: begin
                if (ev_clear || ev_stop) begin
                    state_d = IDLE;
                    time_d  = 16'h0000;
                end else if (ev_start) begin
                    if (bus.door_closed) begin
                        if (state_q == IDLE) begin
                            state_d = COOK;
                            time_d  = 16'h0030;
                        end else if (time_q != 16'h0000) begin
                            state_d = COOK;
                        end
                    end
                end else if (digit_ok) begin
                    state_d = SETUP;
                    time_d  = {time_q[11:0], bus.digit};
                end
            end
            COOK: begin
                if (ev_clear) begin
                    state_d = IDLE;
                    time_d  = 16'h0000;
                end else if (ev_stop || !bus.door_closed) begin
                    state_d = PAUSE;
                end else if (ev_start) begin
                    time_d = bcd_add30(time_q);
                end else if (tick) begin
                    time_d = bcd_dec(time_q);
                    if (time_d == 16'h0000) begin
                        state_d = DONE;
                    end
                end
            end
            PAUSE: begin
                if (ev_clear || ev_stop) begin
                    state_d = IDLE;
                    time_d  = 16'h0000;
                end else if (ev_start && bus.door_closed) begin
                    state_d = COOK;
                end
            end
            DONE: begin
                if (ev_clear || ev_stop || ev_start || door_fall) begin
                    state_d = IDLE;
                    time_d  = 16'h0000;
                end
            end
            default: begin
                state_d = IDLE;
                time_d  = 16'h0000;
            end
        endcase
    end

    always_comb begin
        pre_d = pre_q;
        if (state_d == COOK && state_q != COOK) begin
            pre_d = '0;
`ifdef DONE_BEEP_EN
        end else if (state_d == DONE && state_q != DONE) begin
            pre_d = '0;
`endif
        end else if (pre_run) begin
            pre_d = tick ? '0 : pre_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= IDLE;
            time_q     <= 16'h0000;
            pre_q      <= '0;
            btn_sync_q <= 3'b111;
            btn_prev_q <= 3'b111;
            door_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            time_q     <= time_d;
            pre_q      <= pre_d;
            btn_sync_q <= {bus.clearn, bus.stopn, bus.startn};
            btn_prev_q <= btn_sync_q;
            door_q     <= bus.door_closed;
        end
    end

`ifdef DONE_BEEP_EN
    localparam int BEEP_W = (BEEP_SECS > 1) ? $clog2(BEEP_SECS) : 1;

    logic              beep_q, beep_d;
    logic [BEEP_W-1:0] beep_cnt_q, beep_cnt_d;

    // Counts completed seconds in DONE; the tone stops after the last one.
    always_comb begin
        beep_d     = beep_q;
        beep_cnt_d = beep_cnt_q;
        if (state_d == DONE && state_q != DONE) begin
            beep_d     = 1'b1;
            beep_cnt_d = '0;
        end else if (state_d != DONE) begin
            beep_d = 1'b0;
        end else if (beep_q && tick) begin
            if (beep_cnt_q == BEEP_W'(BEEP_SECS - 1)) begin
                beep_d = 1'b0;
            end else begin
                beep_cnt_d = beep_cnt_q + 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            beep_q     <= 1'b0;
            beep_cnt_q <= '0;
        end else begin
            beep_q     <= beep_d;
            beep_cnt_q <= beep_cnt_d;
        end
    end

    assign bus.beep = beep_q;
`else
    // No tone in this build, whatever BEEP_SECS is set to.
    assign bus.beep = 1'b0 & (BEEP_SECS > 0);
`endif

    // Door is taken straight from the pin so an opening door kills the magnetron at once.
    assign bus.mag_on   = (state_q == COOK) & bus.door_closed;
    assign bus.time_bcd = time_q;
    assign bus.state    = state_q;
    assign bus.done     = (state_q == DONE);
endmodule

// File: tb/tb_magnetron_sequencer.sv
// Bench for magnetron_sequencer: directed test-plan walk plus randomized buttons/keys/door,
// every cycle checked against a minutes/seconds behavioural model.
module tb_magnetron_sequencer;
    localparam int TD = 4;
    localparam int BS = 3;
`ifdef DONE_BEEP_EN
    localparam bit BEEP_EN = 1'b1;
`else
    localparam bit BEEP_EN = 1'b0;
`endif
    localparam int S_IDLE = 0, S_SETUP = 1, S_COOK = 2, S_PAUSE = 3, S_DONE = 4;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    magnetron_sequencer_if bus_if ();

    magnetron_sequencer #(.TICK_DIV(TD), .BEEP_SECS(BS)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus_if)
    );

    always #5 clk = ~clk;

    // Behavioural model: time kept as integer minutes and seconds.
    int       m_st, m_min, m_sec, m_pre, m_beep_left, m_nst, m_total;
    bit [2:0] m_sync, m_prev, m_ev;
    bit       m_door_prev, m_valid = 1'b0, m_run, m_tick, m_dfall;

    function automatic logic [15:0] m_bcd();
        return {4'(m_min / 10), 4'(m_min % 10), 4'(m_sec / 10), 4'(m_sec % 10)};
    endfunction

    task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, want 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    always @(posedge clk) begin
        if (rst) begin
            m_st = S_IDLE; m_min = 0; m_sec = 0; m_pre = 0; m_beep_left = 0;
            m_sync = 3'b111; m_prev = 3'b111; m_door_prev = 1'b0; m_valid = 1'b1;
        end else begin
            m_ev    = m_prev & ~m_sync;
            m_dfall = m_door_prev && !bus_if.door_closed;
            m_run   = (m_st == S_COOK) || (BEEP_EN && m_st == S_DONE);
            m_tick  = m_run && (m_pre == TD - 1);
            m_nst   = m_st;
            case (m_st)
                S_IDLE, S_SETUP: begin
                    if (m_ev[2] || m_ev[1]) begin
                        m_nst = S_IDLE; m_min = 0; m_sec = 0;
                    end else if (m_ev[0]) begin
                        if (bus_if.door_closed && m_st == S_IDLE) begin
                            m_nst = S_COOK; m_min = 0; m_sec = 30;
                        end else if (bus_if.door_closed && (m_min != 0 || m_sec != 0)) begin
                            m_nst = S_COOK;
                        end
                    end else if (bus_if.digit_valid && bus_if.digit <= 9) begin
                        m_nst = S_SETUP;
                        m_min = (m_min % 10) * 10 + m_sec / 10;
                        m_sec = (m_sec % 10) * 10 + int'(bus_if.digit);
                    end
                end
                S_COOK: begin
                    if (m_ev[2]) begin
                        m_nst = S_IDLE; m_min = 0; m_sec = 0;
                    end else if (m_ev[1] || !bus_if.door_closed) begin
                        m_nst = S_PAUSE;
                    end else if (m_ev[0]) begin
                        m_total = m_sec + 30;
                        m_min   = m_min + m_total / 60;
                        m_sec   = m_total % 60;
                        if (m_min > 99) begin m_min = 99; m_sec = 59; end
                    end else if (m_tick) begin
                        if (m_sec > 0) m_sec--;
                        else begin m_min--; m_sec = 59; end
                        if (m_min == 0 && m_sec == 0) m_nst = S_DONE;
                    end
                end
                S_PAUSE: begin
                    if (m_ev[2] || m_ev[1]) begin
                        m_nst = S_IDLE; m_min = 0; m_sec = 0;
                    end else if (m_ev[0] && bus_if.door_closed) begin
                        m_nst = S_COOK;
                    end
                end
                default: begin
                    if (m_ev != 3'b000 || m_dfall) begin
                        m_nst = S_IDLE; m_min = 0; m_sec = 0;
                    end
                end
            endcase
            if (m_nst == S_COOK && m_st != S_COOK) m_pre = 0;
            else if (BEEP_EN && m_nst == S_DONE && m_st != S_DONE) m_pre = 0;
            else if (m_run) m_pre = (m_pre + 1) % TD;
            if (m_nst == S_DONE && m_st != S_DONE) m_beep_left = BEEP_EN ? BS : 0;
            else if (m_nst != S_DONE) m_beep_left = 0;
            else if (m_tick && m_beep_left > 0) m_beep_left--;
            m_st        = m_nst;
            m_prev      = m_sync;
            m_sync      = {bus_if.clearn, bus_if.stopn, bus_if.startn};
            m_door_prev = bus_if.door_closed;
        end
    end

    always @(posedge clk) begin
        #2;
        if (m_valid) begin
            chk("cyc mag_on", 16'(bus_if.mag_on), 16'(m_st == S_COOK && bus_if.door_closed));
            chk("cyc time_bcd", bus_if.time_bcd, m_bcd());
            chk("cyc state", 16'(bus_if.state), 16'(m_st));
            chk("cyc done", 16'(bus_if.done), 16'(m_st == S_DONE));
            chk("cyc beep", 16'(bus_if.beep), 16'(m_beep_left > 0));
        end
    end

    task automatic cyc(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Literal expectation, checked against both the DUT and the model.
    task automatic lit(input string name, input logic [15:0] t, input int s);
        chk({name, " time"}, bus_if.time_bcd, t);
        chk({name, " state"}, 16'(bus_if.state), 16'(s));
        chk({name, " model time"}, m_bcd(), t);
        chk({name, " model state"}, 16'(m_st), 16'(s));
    endtask

    task automatic key(input logic [3:0] d);
        bus_if.digit_valid = 1'b1;
        bus_if.digit       = d;
        cyc(1);
        bus_if.digit_valid = 1'b0;
    endtask

    task automatic keys4(input logic [15:0] v);
        for (int i = 3; i >= 0; i--) key(v[i*4 +: 4]);
    endtask

    // Idle one cycle, hold low two cycles; returns just after the effect edge.
    task automatic press(input int which);
        cyc(1);
        if (which == 0) bus_if.startn = 1'b0;
        else if (which == 1) bus_if.stopn = 1'b0;
        else bus_if.clearn = 1'b0;
        cyc(2);
        bus_if.startn = 1'b1; bus_if.stopn = 1'b1; bus_if.clearn = 1'b1;
    endtask

    function automatic logic btn_next(input logic cur);
        if (cur) return !($urandom_range(0, 39) == 0);
        return ($urandom_range(0, 2) == 0);
    endfunction

    initial begin
        rst = 1'b1;
        bus_if.startn = 1'b1; bus_if.stopn = 1'b1; bus_if.clearn = 1'b1;
        bus_if.door_closed = 1'b0; bus_if.digit_valid = 1'b0; bus_if.digit = 4'd0;
        cyc(3);
        rst = 1'b0;
        lit("reset", 16'h0000, S_IDLE);
        chk("reset mag_on", 16'(bus_if.mag_on), 16'd0);
        chk("reset done", 16'(bus_if.done), 16'd0);
        chk("reset beep", 16'(bus_if.beep), 16'd0);

        keys4(16'h1234);
        lit("keys 1234", 16'h1234, S_SETUP);
        key(4'd5);
        lit("key 5", 16'h2345, S_SETUP);
        key(4'hA);
        lit("key A ignored", 16'h2345, S_SETUP);

        press(2);
        lit("clear", 16'h0000, S_IDLE);
        keys4(16'h0002);
        bus_if.door_closed = 1'b1;
        cyc(1);
        bus_if.startn = 1'b0;
        cyc(1);
        lit("start +1clk", 16'h0002, S_SETUP);
        cyc(1);
        lit("start +2clk", 16'h0002, S_COOK);
        chk("start mag_on", 16'(bus_if.mag_on), 16'd1);
        bus_if.startn = 1'b1;
        cyc(8);
        lit("2 s done", 16'h0000, S_DONE);
        chk("done mag_on", 16'(bus_if.mag_on), 16'd0);
        chk("done flag", 16'(bus_if.done), 16'd1);
        chk("beep start", 16'(bus_if.beep), 16'(BEEP_EN));
        cyc(11);
        chk("beep 11clk", 16'(bus_if.beep), 16'(BEEP_EN));
        cyc(1);
        chk("beep 12clk", 16'(bus_if.beep), 16'd0);
        lit("still done", 16'h0000, S_DONE);
        press(2);
        lit("done clear", 16'h0000, S_IDLE);

        keys4(16'h0100);
        press(0);
        cyc(4);
        lit("0100 tick", 16'h0059, S_COOK);
        press(2);
        press(0);
        lit("quick start", 16'h0030, S_COOK);
        press(0);
        lit("add30 roll", 16'h0100, S_COOK);
        press(2);
        keys4(16'h9950);
        press(0);
        press(0);
        lit("add30 sat", 16'h9959, S_COOK);

        press(2);
        keys4(16'h0010);
        press(0);
        bus_if.door_closed = 1'b0;
        #1;
        chk("door mag_on", 16'(bus_if.mag_on), 16'd0);
        chk("door state", 16'(bus_if.state), 16'(S_COOK));
        cyc(1);
        lit("door pause", 16'h0010, S_PAUSE);
        cyc(6);
        lit("pause frozen", 16'h0010, S_PAUSE);
        bus_if.door_closed = 1'b1;
        press(0);
        lit("resume", 16'h0010, S_COOK);
        cyc(4);
        lit("resume tick", 16'h0009, S_COOK);

        press(2);
        press(0);
        lit("idle quick", 16'h0030, S_COOK);
        press(1);
        lit("stop pause", 16'h0030, S_PAUSE);
        press(1);
        lit("stop idle", 16'h0000, S_IDLE);
        key(4'd5);
        bus_if.door_closed = 1'b0;
        press(0);
        lit("door open start", 16'h0005, S_SETUP);
        bus_if.door_closed = 1'b1;
        press(0);
        lit("setup start", 16'h0005, S_COOK);
        cyc(1);
        bus_if.startn = 1'b0; bus_if.stopn = 1'b0; bus_if.clearn = 1'b0;
        cyc(2);
        bus_if.startn = 1'b1; bus_if.stopn = 1'b1; bus_if.clearn = 1'b1;
        lit("all buttons", 16'h0000, S_IDLE);

        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 599) == 0);
            bus_if.startn = btn_next(bus_if.startn);
            bus_if.stopn  = btn_next(bus_if.stopn);
            bus_if.clearn = btn_next(bus_if.clearn);
            if (bus_if.door_closed) bus_if.door_closed = !($urandom_range(0, 149) == 0);
            else bus_if.door_closed = ($urandom_range(0, 7) == 0);
            bus_if.digit_valid = ($urandom_range(0, 5) == 0);
            bus_if.digit = ($urandom_range(0, 1) == 0) ? 4'($urandom_range(0, 15))
                                                      : 4'($urandom_range(0, 3));
        end
        rst = 1'b0;
        cyc(2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
